// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: requester IDs, default widths and read-tracker entry layout.
package mem_port_arbiter_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDRESS_BITS = 20;
  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;
  typedef struct packed {
    logic id;
    logic [DEF_ADDRESS_BITS-1:0] address;
  } trk_entry_t;
endpackage

// File: rtl/arb_read_tracker.sv
// arb_read_tracker: in-order FIFO of outstanding reads, {id, address} per entry.
module arb_read_tracker #(
  parameter int W = 21,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    wr_d = push ? nxt(wr_q) : wr_q;
    rd_d = pop ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  // Storage needs no reset: only entries counted by cnt_q are ever read.
  always_ff @(posedge clock)
    if (push) mem_q[wr_q] <= push_data;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between icache (0) and dcache (1).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    c0_read,
  input  logic                    c0_write,
  input  logic [ADDRESS_BITS-1:0] c0_address,
  input  logic [DATA_WIDTH-1:0]   c0_data_in,
  output logic                    c0_ready,
  output logic                    c0_valid,
  output logic [DATA_WIDTH-1:0]   c0_data_out,
  output logic [ADDRESS_BITS-1:0] c0_out_address,
  input  logic                    c1_read,
  input  logic                    c1_write,
  input  logic [ADDRESS_BITS-1:0] c1_address,
  input  logic [DATA_WIDTH-1:0]   c1_data_in,
  output logic                    c1_ready,
  output logic                    c1_valid,
  output logic [DATA_WIDTH-1:0]   c1_data_out,
  output logic [ADDRESS_BITS-1:0] c1_out_address,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic                    protocol_error,
  output logic [31:0]             conflict_count
);
  logic pend0, pend1, can_issue, g0, g1, full, empty, pop;
  logic [ADDRESS_BITS:0] head;
  logic last_q, last_d, perr_q, perr_d;
  logic v0_q, v0_d, v1_q, v1_d;
  logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
  logic [ADDRESS_BITS-1:0] a0_q, a0_d, a1_q, a1_d;
  logic [31:0] conf_q, conf_d;
  assign pend0 = c0_read | c0_write;
  assign pend1 = c1_read | c1_write;
  // Gating with reset keeps every request-side output low while reset is held.
  assign can_issue = reset & mem_ready & (!full | mem_valid);
  assign g0 = can_issue & pend0 & (!pend1 | last_q == REQ_DCACHE);
  assign g1 = can_issue & pend1 & (!pend0 | last_q == REQ_ICACHE);
  assign c0_ready = g0;
  assign c1_ready = g1;
  assign mem_read = g0 ? c0_read : g1 & c1_read;
  assign mem_write = g0 ? c0_write & !c0_read : g1 & c1_write & !c1_read;
  assign mem_address = g0 ? c0_address : g1 ? c1_address : '0;
  assign mem_data_out = g0 ? c0_data_in : g1 ? c1_data_in : '0;
  assign pop = mem_valid & !empty;
  arb_read_tracker #(.W(ADDRESS_BITS + 1), .DEPTH(MAX_OUTSTANDING)) u_trk (
    .clock(clock),
    .reset(reset),
    .push(mem_read),
    .pop(pop),
    .push_data({g1 ? REQ_DCACHE : REQ_ICACHE, mem_address}),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_comb begin
    last_d = g0 ? REQ_ICACHE : g1 ? REQ_DCACHE : last_q;
    perr_d = perr_q | (c0_read & c0_write) | (c1_read & c1_write) | (mem_valid & empty);
    conf_d = conf_q + 32'(pend0 & pend1);
    v0_d = pop & head[ADDRESS_BITS] == REQ_ICACHE;
    v1_d = pop & head[ADDRESS_BITS] == REQ_DCACHE;
    d0_d = v0_d ? mem_data_in : d0_q;
    d1_d = v1_d ? mem_data_in : d1_q;
    a0_d = v0_d ? head[ADDRESS_BITS-1:0] : a0_q;
    a1_d = v1_d ? head[ADDRESS_BITS-1:0] : a1_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      last_q <= REQ_DCACHE;
      perr_q <= 1'b0;
      conf_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
      a0_q <= '0;
      a1_q <= '0;
    end else begin
      last_q <= last_d;
      perr_q <= perr_d;
      conf_q <= conf_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      a0_q <= a0_d;
      a1_q <= a1_d;
    end
  assign c0_valid = v0_q;
  assign c1_valid = v1_q;
  assign c0_data_out = d0_q;
  assign c1_data_out = d1_q;
  assign c0_out_address = a0_q;
  assign c1_out_address = a1_q;
  assign protocol_error = perr_q;
  assign conflict_count = conf_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random stimulus against a queue-based reference model with a response scoreboard.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 20;
  localparam int DEPTH = 2;
  logic clock = 1'b0, reset = 1'b0;
  logic c0_read = 0, c0_write = 0, c1_read = 0, c1_write = 0;
  logic [AW-1:0] c0_address = '0, c1_address = '0;
  logic [DW-1:0] c0_data_in = '0, c1_data_in = '0;
  logic c0_ready, c0_valid, c1_ready, c1_valid;
  logic [DW-1:0] c0_data_out, c1_data_out;
  logic [AW-1:0] c0_out_address, c1_out_address;
  logic mem_read, mem_write, mem_ready = 0, mem_valid = 0;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_out, mem_data_in = '0;
  logic protocol_error;
  logic [31:0] conflict_count;
  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MAX_OUTSTANDING(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .c0_read(c0_read), .c0_write(c0_write), .c0_address(c0_address), .c0_data_in(c0_data_in),
    .c0_ready(c0_ready), .c0_valid(c0_valid), .c0_data_out(c0_data_out), .c0_out_address(c0_out_address),
    .c1_read(c1_read), .c1_write(c1_write), .c1_address(c1_address), .c1_data_in(c1_data_in),
    .c1_ready(c1_ready), .c1_valid(c1_valid), .c1_data_out(c1_data_out), .c1_out_address(c1_out_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_data_in(mem_data_in),
    .protocol_error(protocol_error), .conflict_count(conflict_count)
  );
  always #5 clock = ~clock;
  typedef struct packed {logic id; logic [AW-1:0] addr;} ent_t;
  typedef struct packed {logic id; logic [DW-1:0] data; logic [AW-1:0] addr;} resp_t;
  ent_t trk[$];
  resp_t exp_q[$];
  int errors = 0, checks = 0;
  logic m_last = 1'b1, m_perr = 1'b0;
  logic [31:0] m_conf = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Scoreboard monitor: each queued response must appear exactly one cycle after its mem_valid.
  initial begin
    resp_t r;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("c0_valid", c0_valid, r.id == 1'b0);
        chk("c1_valid", c1_valid, r.id == 1'b1);
        chk("data_out", r.id ? c1_data_out : c0_data_out, r.data);
        chk("out_address", r.id ? c1_out_address : c0_out_address, r.addr);
      end else
        chk("no_valid", {c0_valid, c1_valid}, 2'b00);
    end
  end
  task automatic step(input logic r0, w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic mr, mv, input logic [DW-1:0] md);
    int win;
    logic p0, p1, wr_r;
    ent_t e;
    @(posedge clock);
    #2;
    c0_read = r0; c0_write = w0; c0_address = a0; c0_data_in = d0;
    c1_read = r1; c1_write = w1; c1_address = a1; c1_data_in = d1;
    mem_ready = mr; mem_valid = mv; mem_data_in = md;
    #2;
    p0 = r0 | w0;
    p1 = r1 | w1;
    win = -1;
    if (mr && (trk.size() < DEPTH || mv) && (p0 || p1))
      win = (p0 && p1) ? (m_last ? 0 : 1) : (p0 ? 0 : 1);
    wr_r = win == 0 ? r0 : r1;
    chk("c0_ready", c0_ready, win == 0);
    chk("c1_ready", c1_ready, win == 1);
    chk("mem_read", mem_read, win >= 0 && wr_r);
    chk("mem_write", mem_write, win >= 0 && !wr_r && (win == 0 ? w0 : w1));
    chk("mem_address", mem_address, win == 0 ? a0 : win == 1 ? a1 : '0);
    chk("mem_data_out", mem_data_out, win == 0 ? d0 : win == 1 ? d1 : '0);
    chk("protocol_error", protocol_error, m_perr);
    chk("conflict_count", conflict_count, m_conf);
    if (mv) begin
      if (trk.size() > 0) begin
        e = trk.pop_front();
        exp_q.push_back({e.id, md, e.addr});
      end else m_perr = 1'b1;
    end
    if (win >= 0 && wr_r) trk.push_back({win == 1, win == 0 ? a0 : a1});
    if ((r0 && w0) || (r1 && w1)) m_perr = 1'b1;
    if (p0 && p1) m_conf++;
    if (win >= 0) m_last = win[0];
  endtask
  task automatic idle(input logic mv, input logic [DW-1:0] md);
    step(0, 0, '0, '0, 0, 0, '0, '0, 1, mv, md);
  endtask
  task automatic drain();
    while (trk.size() > 0) idle(1, $urandom);
    idle(0, '0);
  endtask
  task automatic zero_inputs();
    c0_read = 0; c0_write = 0; c0_address = '0; c0_data_in = '0;
    c1_read = 0; c1_write = 0; c1_address = '0; c1_data_in = '0;
    mem_ready = 0; mem_valid = 0; mem_data_in = '0;
  endtask
  task automatic check_reset_outputs();
    chk("rst_c0_ready", c0_ready, 0);
    chk("rst_c1_ready", c1_ready, 0);
    chk("rst_valids", {c0_valid, c1_valid}, 2'b00);
    chk("rst_data", {c0_data_out, c1_data_out}, '0);
    chk("rst_addr", {c0_out_address, c1_out_address}, '0);
    chk("rst_mem_req", {mem_read, mem_write}, 2'b00);
    chk("rst_mem_addr", mem_address, '0);
    chk("rst_mem_data", mem_data_out, '0);
    chk("rst_perr", protocol_error, 0);
    chk("rst_conflict", conflict_count, '0);
  endtask
  initial begin
    logic mv;
    #1;
    check_reset_outputs();
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b1;
    // Single read, response two cycles after issue
    step(1, 0, 20'h00010, '0, 0, 0, '0, '0, 1, 0, '0);
    idle(0, '0);
    idle(1, 32'hDEADBEEF);
    idle(0, '0);
    idle(0, '0);
    // Contention: both requesters read every cycle
    for (int i = 0; i < 10; i++) begin
      mv = i >= 3 && trk.size() > 0;
      step(1, 0, AW'(32'h100 + i), $urandom, 1, 0, AW'(32'h200 + i), $urandom, 1, mv, $urandom);
    end
    drain();
    // Tracker full, then a pop frees the slot in the same cycle
    step(1, 0, 20'h00A00, '0, 0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, '0, 1, 0, 20'h00B00, '0, 1, 0, '0);
    step(1, 0, 20'h00C00, '0, 0, 0, '0, '0, 1, 0, '0);
    step(1, 0, 20'h00C00, '0, 0, 0, '0, '0, 1, 1, 32'hA5A5A5A5);
    drain();
    // Posted write
    step(0, 0, '0, '0, 0, 1, 20'h00400, 32'h12345678, 1, 0, '0);
    idle(0, '0);
    idle(0, '0);
    // Protocol errors
    idle(1, 32'h0BAD0BAD);
    idle(0, '0);
    step(1, 1, 20'h00777, 32'h55555555, 0, 0, '0, '0, 1, 0, '0);
    drain();
    idle(0, '0);
    // Reset mid-flight with two reads outstanding
    step(1, 0, 20'h00D00, '0, 0, 0, '0, '0, 1, 0, '0);
    step(0, 0, '0, '0, 1, 0, 20'h00E00, '0, 1, 0, '0);
    step(1, 0, 20'h00F00, '0, 1, 0, 20'h00F10, '0, 1, 0, '0);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check_reset_outputs();
    trk.delete();
    exp_q.delete();
    m_last = 1'b1; m_perr = 1'b0; m_conf = '0;
    zero_inputs();
    @(posedge clock);
    #3 reset = 1'b1;
    idle(1, 32'hCAFEF00D);
    step(1, 0, 20'h00123, '0, 1, 0, 20'h00456, '0, 1, 0, '0);
    drain();
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic r0, w0, r1, w1, mr;
      r0 = $urandom_range(0, 2) == 0;
      w0 = !r0 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 63) == 0;
      r1 = $urandom_range(0, 2) == 0;
      w1 = !r1 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 63) == 0;
      mr = $urandom_range(0, 3) != 0;
      mv = trk.size() > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 49) == 0;
      step(r0, w0, AW'($urandom), $urandom, r1, w1, AW'($urandom), $urandom, mr, mv, $urandom);
    end
    drain();
    idle(0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
